alu_unit: RTL and testbench

Integer execution unit at the far end of the reservation-station issue interface. It accepts one ready instruction per cycle, with operands, ROB id and operation type, and computes the result. It then broadcasts the result on the ALU result bus, which the reservation station snoops for wakeup and forwards to the ROB. The unit is fully pipelined, never back-pressures, and drops all in-flight work on a ROB flush.

---
 rtl/alu_unit.sv | 90 +++++++++
 tb/tb_alu_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// alu_unit: pipelined integer ALU that broadcasts results on the ALU result bus.
// Define ALU_PIPE2_EN to register the issue bus first (latency 2 instead of 1).
module alu_unit #(
  parameter int OP_W  = 4,
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             rs_shot,
  input  logic [31:0]      alu_r1,
  input  logic [31:0]      alu_r2,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [OP_W-1:0]  alu_work_type,
  output logic             alu_ready,
  output logic [ROB_W-1:0] inputalu_rob_id,
  output logic [31:0]      alu_value,
  output logic             alu_idle
);
  logic             e_v;
  logic [31:0]      e_a, e_b, res;
  logic [ROB_W-1:0] e_rob;
  logic [OP_W-1:0]  e_op;
  logic [3:0]       op;
  logic [4:0]       sh;
`ifdef ALU_PIPE2_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_v   <= 1'b0;
      e_a   <= '0;
      e_b   <= '0;
      e_rob <= '0;
      e_op  <= '0;
    end else if (rdy) begin
      e_v <= rs_shot && !clear;
      if (rs_shot) begin
        e_a   <= alu_r1;
        e_b   <= alu_r2;
        e_rob <= alu_rob_id;
        e_op  <= alu_work_type;
      end
    end
  end
  assign alu_idle = !(e_v || alu_ready);
`else
  assign e_v   = rs_shot;
  assign e_a   = alu_r1;
  assign e_b   = alu_r2;
  assign e_rob = alu_rob_id;
  assign e_op  = alu_work_type;
  assign alu_idle = !alu_ready;
`endif
  always_comb begin
    op  = e_op[3:0];
    sh  = e_b[4:0];
    res = '0;
    case (op)
      4'd0:        res = e_a + e_b;
      4'd1:        res = e_a - e_b;
      4'd2:        res = e_a & e_b;
      4'd3:        res = e_a | e_b;
      4'd4:        res = e_a ^ e_b;
      4'd5:        res = e_a << sh;
      4'd6:        res = e_a >> sh;
      4'd7:        res = $unsigned($signed(e_a) >>> sh);
      4'd8, 4'd12: res = {31'b0, $signed(e_a) < $signed(e_b)};
      4'd9, 4'd14: res = {31'b0, e_a < e_b};
      4'd10:       res = {31'b0, e_a == e_b};
      4'd11:       res = {31'b0, e_a != e_b};
      4'd13:       res = {31'b0, $signed(e_a) >= $signed(e_b)};
      4'd15:       res = {31'b0, e_a >= e_b};
      default:     res = '0;
    endcase
  end
  // A clear kills whatever would land in the output stage on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_ready       <= 1'b0;
      inputalu_rob_id <= '0;
      alu_value       <= '0;
    end else if (rdy) begin
      alu_ready <= e_v && !clear;
      if (e_v) begin
        inputalu_rob_id <= e_rob;
        alu_value       <= res;
      end
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed self-checking bench for alu_unit in either pipeline mode.
module tb_alu_unit;
`ifdef ALU_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int ROB_W = 4;
  logic             clk, rst, rdy, clear, rs_shot;
  logic [31:0]      alu_r1, alu_r2, alu_value;
  logic [ROB_W-1:0] alu_rob_id, inputalu_rob_id;
  logic [3:0]       alu_work_type;
  logic             alu_ready, alu_idle;
  int checks = 0;
  int errors = 0;
  logic [3:0]       t_op[3];
  logic [31:0]      t_a[3], t_b[3], t_exp[3];
  logic [ROB_W-1:0] t_rob[3];

  alu_unit #(.OP_W(4), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .rs_shot(rs_shot),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_rob_id(alu_rob_id),
    .alu_work_type(alu_work_type), .alu_ready(alu_ready),
    .inputalu_rob_id(inputalu_rob_id), .alu_value(alu_value), .alu_idle(alu_idle)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [ROB_W-1:0] rob);
    rs_shot = 1; alu_work_type = op; alu_r1 = a; alu_r2 = b; alu_rob_id = rob;
  endtask

  task automatic ld(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [ROB_W-1:0] rob, input logic [31:0] e);
    t_op[i] = op; t_a[i] = a; t_b[i] = b; t_rob[i] = rob; t_exp[i] = e;
  endtask

  // Issues three back-to-back ops and expects three back-to-back pulses LAT edges later.
  task automatic run3(input string tag);
    for (int k = 0; k < 3 + LAT; k++) begin
      if (k < 3) drive(t_op[k], t_a[k], t_b[k], t_rob[k]);
      else rs_shot = 0;
      step();
      if (k + 1 - LAT >= 0 && k + 1 - LAT < 3) begin
        chk({tag, "_ready"}, {31'b0, alu_ready}, 32'd1);
        chk({tag, "_value"}, alu_value, t_exp[k + 1 - LAT]);
        chk({tag, "_rob"}, {28'b0, inputalu_rob_id}, {28'b0, t_rob[k + 1 - LAT]});
      end else chk({tag, "_noready"}, {31'b0, alu_ready}, 32'd0);
    end
    step();
    chk({tag, "_after"}, {31'b0, alu_ready}, 32'd0);
    chk({tag, "_idle"}, {31'b0, alu_idle}, 32'd1);
  endtask

  initial begin
    int e;
    logic stall_rdy[7];
    stall_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst = 0; rdy = 1; clear = 0; rs_shot = 0;
    alu_r1 = 0; alu_r2 = 0; alu_rob_id = 0; alu_work_type = 0;
    repeat (3) step();
    chk("rst_ready", {31'b0, alu_ready}, 32'd0);
    chk("rst_value", alu_value, 32'd0);
    chk("rst_rob", {28'b0, inputalu_rob_id}, 32'd0);
    chk("rst_idle", {31'b0, alu_idle}, 32'd1);
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_noready", {31'b0, alu_ready}, 32'd0);
    end

    ld(0, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'h0000_0000);
    ld(1, 4'd1, 32'd0, 32'd1, 4'd4, 32'hFFFF_FFFF);
    ld(2, 4'd7, 32'h8000_0000, 32'd33, 4'd5, 32'hC000_0000);
    run3("arith");
    ld(0, 4'd8, 32'hFFFF_FFFF, 32'd1, 4'd1, 32'd1);
    ld(1, 4'd9, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd0);
    ld(2, 4'd15, 32'd5, 32'd5, 4'd6, 32'd1);
    run3("cmp");
    ld(0, 4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd9, 32'h00F0_000F);
    ld(1, 4'd3, 32'h0000_1200, 32'h0000_0034, 4'd10, 32'h0000_1234);
    ld(2, 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd11, 32'hF0F0_0F0F);
    run3("logic");
    ld(0, 4'd5, 32'd1, 32'd31, 4'd12, 32'h8000_0000);
    ld(1, 4'd6, 32'h8000_0000, 32'd4, 4'd13, 32'h0800_0000);
    ld(2, 4'd10, 32'd7, 32'd7, 4'd14, 32'd1);
    run3("shift");
    ld(0, 4'd11, 32'd3, 32'd3, 4'd15, 32'd0);
    ld(1, 4'd12, 32'hFFFF_FFFE, 32'd1, 4'd0, 32'd1);
    ld(2, 4'd13, 32'hFFFF_FFFF, 32'd1, 4'd1, 32'd0);
    run3("scmp");
    ld(0, 4'd14, 32'd1, 32'hFFFF_FFFE, 4'd2, 32'd1);
    ld(1, 4'd0, 32'h7FFF_FFFF, 32'd1, 4'd3, 32'h8000_0000);
    ld(2, 4'd1, 32'd5, 32'd7, 4'd4, 32'hFFFF_FFFE);
    run3("misc");

    drive(4'd0, 32'd100, 32'd1, 4'd7);
    step();
    chk("flush_rob7_ready", {31'b0, alu_ready}, 32'(LAT == 1));
    drive(4'd0, 32'd200, 32'd1, 4'd8);
    clear = 1;
    step();
    rs_shot = 0; clear = 0;
    chk("flush_ready", {31'b0, alu_ready}, 32'd0);
    chk("flush_idle", {31'b0, alu_idle}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_noready", {31'b0, alu_ready}, 32'd0);
    end

    drive(4'd0, 32'd10, 32'd20, 4'd2);
    e = 0;
    for (int i = 0; i < 7; i++) begin
      rdy = stall_rdy[i];
      step();
      rs_shot = 0;
      if (stall_rdy[i]) e++;
      chk("stall_ready", {31'b0, alu_ready}, 32'(e == LAT));
      if (e == LAT) chk("stall_value", alu_value, 32'd30);
    end
    rdy = 1;

    drive(4'd0, 32'd1, 32'd1, 4'd5);
    step();
    drive(4'd0, 32'd2, 32'd2, 4'd6);
    step();
    rs_shot = 0;
    chk("async_pre_ready", {31'b0, alu_ready}, 32'd1);
    #2 rst = 0;
    #1;
    chk("async_ready", {31'b0, alu_ready}, 32'd0);
    chk("async_value", alu_value, 32'd0);
    chk("async_idle", {31'b0, alu_idle}, 32'd1);
    step();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("async_noready", {31'b0, alu_ready}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
